// File: rtl/countdown_display_pkg.sv
// Shared types and constants for the countdown display: converter FSM states,
// active-low seven-segment patterns {g,f,e,d,c,b,a} and BCD/binary widths.
package countdown_display_pkg;

  localparam int BIN_BITS = 16;
  localparam int BCD_BITS = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_G     = 7'b1000010;

  // Non-decimal nibbles decode to blank; the top uses 4'hF as its "no digit" code.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one load, 16 add-3/shift cycles, then a
// one-cycle LOAD state in which done is high and bcd holds the result.
module bin2bcd_serial
  import countdown_display_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [BIN_BITS-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic [BCD_BITS-1:0] bcd
);

  state_t                       state_q, state_d;
  logic [BCD_BITS+BIN_BITS-1:0] sr_q, sr_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [BCD_BITS-1:0]          adj;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    adj     = sr_q[BCD_BITS+BIN_BITS-1:BIN_BITS];
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d    = {{BCD_BITS{1'b0}}, bin};
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int i = 0; i < BCD_BITS / 4; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        sr_d  = {adj, sr_q[BIN_BITS-1:0]} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_LOAD);
  assign bcd  = sr_q[BCD_BITS+BIN_BITS-1:BIN_BITS];

endmodule

// File: rtl/countdown_display.sv
// Four-digit multiplexed seven-segment display of the upstream count, with
// input stability filtering, overflow dashes and a "GO" override on start.
module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        start,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            PW      = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]         c_q, c_d, last_q, last_d;
  logic                s_q, s_d, start_f_q, start_f_d, first_q, first_d;
  logic [15:0]         digit_q, digit_d;
  logic                ovf_q, ovf_d;
  logic [3:0][6:0]     disp_q, disp_d;
  logic [1:0]          idx_q, idx_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                conv_load, conv_busy, conv_done;
  logic [BCD_BITS-1:0] conv_bcd;
  logic                lead3, lead2, lead1;

  bin2bcd_serial u_conv (
    .clock (clock),
    .reset (reset),
    .load  (conv_load),
    .bin   (c_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    c_d       = count;
    s_d       = start;
    start_f_d = (start == s_q) ? s_q : start_f_q;
    // A count is accepted only once it matches its registered copy.
    conv_load = !conv_busy && (count == c_q) && ((c_q != last_q) || first_q);
    last_d    = conv_load ? c_q : last_q;
    first_d   = conv_load ? 1'b0 : first_q;

    digit_d = digit_q;
    ovf_d   = ovf_q;
    if (conv_done) begin
      digit_d = conv_bcd[15:0];
      // A non-zero ten-thousands nibble is exactly last > 9999.
      ovf_d   = (conv_bcd[19:16] != 4'd0);
    end

    lead3 = (digit_q[15:12] != 4'd0);
    lead2 = lead3 || (digit_q[11:8] != 4'd0);
    lead1 = lead2 || (digit_q[7:4] != 4'd0);
    if (start_f_q) begin
      disp_d = {SEG_BLANK, SEG_BLANK, SEG_G, SEG_0};
    end else if (ovf_q) begin
      disp_d = {4{SEG_DASH}};
    end else begin
      disp_d[3] = lead3 ? digit_to_seg(digit_q[15:12]) : SEG_BLANK;
      disp_d[2] = lead2 ? digit_to_seg(digit_q[11:8])  : SEG_BLANK;
      disp_d[1] = lead1 ? digit_to_seg(digit_q[7:4])   : SEG_BLANK;
      disp_d[0] = digit_to_seg(digit_q[3:0]);
    end

    // Outputs present the current index on wrap, then the index advances.
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
      an_d  = ~(4'b0001 << idx_q);
      seg_d = disp_q[idx_q];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_q       <= '0;
      s_q       <= 1'b0;
      start_f_q <= 1'b0;
      last_q    <= '0;
      first_q   <= 1'b1;
      digit_q   <= 16'hFFFF;
      ovf_q     <= 1'b0;
      // NOTE: the digit pattern array is reset too, so the display is blank until a value converts.
      disp_q    <= {4{SEG_BLANK}};
      idx_q     <= '0;
      pre_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      c_q       <= c_d;
      s_q       <= s_d;
      start_f_q <= start_f_d;
      last_q    <= last_d;
      first_q   <= first_d;
      digit_q   <= digit_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
      idx_q     <= idx_d;
      pre_q     <= pre_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
